hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 16, number of architectural registers; REGW = clog2(NREG).
REQ-002 Parameter DEPTH, default 3, tracked stages after decode (1=EX, 2=MEM, 3=WB); legal range 2..6.
REQ-003 Parameter LOAD_RDY, default 2, first stage whose output holds load data; legal range 2..DEPTH.
REQ-004 Parameter CNTW, default 32, width of the performance counters.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 id_valid  in  1  decode holds a real instruction.
REQ-008 id_src1, id_src2  in  REGW each  source register indices.
REQ-009 id_use1, id_use2  in  1 each  the source is actually read (immediate or PC operand gives 0).
REQ-010 id_dst  in  REGW  destination index; id_wreg  in  1  writes the register file; id_load  in  1  result comes from memory.
REQ-011 flush  in  1  taken jump resolved in EX this cycle.
REQ-012 mem_wait  in  1  memory not ready; whole back end frozen.
REQ-013 stall  out  1  hold PC and fetch/decode registers this cycle.
REQ-014 issue  out  1  decode instruction enters EX at this edge.
REQ-015 fwd1, fwd2  out  clog2(DEPTH+1) each  operand source: 0 = register file, s = output of stage s.
REQ-016 busy  out  1  any tracked stage valid.
REQ-017 stall_cnt, flush_cnt  out  CNTW each  saturating event counters.

Function
REQ-018 Shadow pipeline of DEPTH entries {valid, dst, wreg, load}; entry s mirrors the instruction in stage s.
REQ-019 Match on source k: id_usek, entry s valid, entry s wreg, entry s dst == id_srck.
REQ-020 fwdk = lowest-numbered (youngest) matching s; 0 when no match or id_usek = 0.
REQ-021 Load-use hazard: youngest match is a load with s < LOAD_RDY; fwdk then forced to 0.
REQ-022 stall = mem_wait OR (id_valid AND load-use hazard on either source AND NOT flush).
REQ-023 issue = id_valid AND NOT stall AND NOT flush.
REQ-024 Edge, mem_wait = 1: shadow frozen, no shift, flush ignored (producer holds flush until mem_wait = 0).
REQ-025 Edge, mem_wait = 0: entries shift s -> s+1, entry DEPTH retires; entry 1 loads the decode fields with valid = issue (bubble otherwise).
REQ-026 flush kills only the decode slot (entry 1 gets bubble); the jump and older instructions in entries >= 1 are unaffected.
REQ-027 flush and load-use hazard same cycle: flush wins; stall = 0, bubble inserted.
REQ-028 stall, issue, fwd1, fwd2 are combinational from inputs and shadow state; zero-cycle latency.
REQ-029 Entry DEPTH match forwards (fwd = DEPTH) to cover write-then-read in the same cycle.
REQ-030 stall_cnt +1 on each cycle stall = 1; flush_cnt +1 on each cycle flush = 1 and mem_wait = 0; both hold at all-ones.
REQ-031 busy = OR of all entry valid bits.

Reset
REQ-032 While rst = 1 at an edge: all entry valid bits 0, dst/wreg/load 0, both counters 0.
REQ-033 Outputs after reset: stall = mem_wait, issue = id_valid AND NOT mem_wait AND NOT flush, fwd1 = fwd2 = 0, busy = 0.
REQ-034 Reset mid-operation discards all in-flight entries; no retire or counter update that cycle.

Structure
REQ-035 Shared package hazard_pkg: forwarding-select type, stage-index type, shadow-entry struct, default parameter constants.
REQ-036 One sub-module, scoreboard_stage: a single shadow entry with enable (NOT mem_wait) and synchronous clear; instantiated DEPTH times via generate.

Verification
REQ-037 ALU r3 in EX, decode reads r3 on src1 -> fwd1 = 1, stall = 0, issue = 1.
REQ-038 Load r5 in EX, decode reads r5 on src2 -> stall = 1 for 1 cycle, then fwd2 = 2, issue = 1; stall_cnt = 1.
REQ-039 r7 written in EX and MEM, decode reads r7 -> fwd1 = 1 (youngest wins).
REQ-040 Load-use hazard with flush = 1 same cycle -> stall = 0, issue = 0, entry 1 bubble, flush_cnt = 1.
REQ-041 mem_wait held 4 cycles with 3 valid entries -> stall = 1 all 4 cycles, shadow unchanged, busy = 1, stall_cnt = 4.
REQ-042 CNTW = 4, 20 consecutive stall cycles -> stall_cnt = 15; rst = 1 mid-stream -> counters 0, busy = 0 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types and default constants for the hazard scoreboard.
//   - NREG_DEF / DEPTH_DEF / LOAD_RDY_DEF / CNTW_DEF : default parameter values
//   - reg_idx_t   : register index, sized for the largest supported NREG (256)
//   - fwd_sel_t   : operand source select (0 = register file, s = stage s)
//   - stage_idx_t : shadow stage index (1..DEPTH, DEPTH <= 6)
//   - sb_entry_t  : one shadow pipeline entry {valid, dst, wreg, load}
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int NREG_DEF     = 16;
    localparam int DEPTH_DEF    = 3;
    localparam int LOAD_RDY_DEF = 2;
    localparam int CNTW_DEF     = 32;

    // Widest register index and stage index the package types can carry.
    localparam int REGW_MAX = 8;
    localparam int SELW     = 3;

    typedef logic [REGW_MAX-1:0] reg_idx_t;
    typedef logic [SELW-1:0]     fwd_sel_t;
    typedef logic [SELW-1:0]     stage_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dst;
        logic     wreg;
        logic     load;
    } sb_entry_t;

    // A source depends on an entry when it is really read and the entry holds
    // a live instruction that writes the same register.
    function automatic logic src_match(sb_entry_t e, logic use_src, reg_idx_t src);
        return use_src && e.valid && e.wreg && (e.dst == src);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
// Decode-side bundle between the pipeline control and the hazard scoreboard.
//   master (pipeline control) drives : id_valid, id_src1/2, id_use1/2, id_dst,
//                                      id_wreg, id_load, flush, mem_wait
//   slave  (scoreboard) drives       : stall, issue, fwd1/2, busy,
//                                      stall_cnt, flush_cnt
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNTW  = CNTW_DEF
);
    localparam int REGW = $clog2(NREG);
    localparam int FW   = $clog2(DEPTH + 1);

    logic            id_valid;
    logic [REGW-1:0] id_src1;
    logic [REGW-1:0] id_src2;
    logic            id_use1;
    logic            id_use2;
    logic [REGW-1:0] id_dst;
    logic            id_wreg;
    logic            id_load;
    logic            flush;
    logic            mem_wait;

    logic            stall;
    logic            issue;
    logic [FW-1:0]   fwd1;
    logic [FW-1:0]   fwd2;
    logic            busy;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_use1, id_use2,
               id_dst, id_wreg, id_load, flush, mem_wait,
        input  stall, issue, fwd1, fwd2, busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use1, id_use2,
               id_dst, id_wreg, id_load, flush, mem_wait,
        output stall, issue, fwd1, fwd2, busy, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_stage.sv
// ----------------------------------------------------------------------------
// scoreboard_stage
// One shadow pipeline entry mirroring the instruction held in one back-end
// stage.
//   clk, rst : clock, synchronous active-high clear
//   en       : advance enable (low while the back end is frozen)
//   d        : entry arriving from the previous stage (or from decode)
//   q        : entry currently held
// ----------------------------------------------------------------------------
module scoreboard_stage
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  sb_entry_t d,
    output sb_entry_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks the destinations of instructions in flight after decode, selects
// forwarding sources for the decode operands and detects load-use hazards.
//   Parameters: NREG (registers), DEPTH (tracked stages, 2..6),
//               LOAD_RDY (first stage holding load data, 2..DEPTH),
//               CNTW (performance counter width)
//   clk  : sole clock
//   rst  : synchronous active-high reset
//   bus  : hazard_scoreboard_if.slave
//          in : id_valid, id_src1/2, id_use1/2, id_dst, id_wreg, id_load,
//               flush, mem_wait
//          out: stall, issue, fwd1/2, busy, stall_cnt, flush_cnt
// ----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LOAD_RDY = LOAD_RDY_DEF,
    parameter int CNTW     = CNTW_DEF
)(
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);

    localparam int FW = $clog2(DEPTH + 1);

    sb_entry_t  ent  [1:DEPTH];
    sb_entry_t  d_in [1:DEPTH];

    stage_idx_t m1, m2;
    logic       ld1, ld2;
    logic       hz1, hz2;
    fwd_sel_t   sel1, sel2;
    logic       stall_w;
    logic       issue_w;
    logic       busy_w;

    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] flush_cnt_q;

    // Youngest producer per source. Scanning from the oldest stage down lets
    // the lowest-numbered match overwrite older ones.
    always_comb begin
        m1  = '0;
        m2  = '0;
        ld1 = 1'b0;
        ld2 = 1'b0;
        for (int s = DEPTH; s >= 1; s--) begin
            if (src_match(ent[s], bus.id_use1, reg_idx_t'(bus.id_src1))) begin
                m1  = stage_idx_t'(s);
                ld1 = ent[s].load;
            end
            if (src_match(ent[s], bus.id_use2, reg_idx_t'(bus.id_src2))) begin
                m2  = stage_idx_t'(s);
                ld2 = ent[s].load;
            end
        end
    end

    // A load whose data is not yet at a stage output cannot be forwarded;
    // the operand select drops to 0 and decode must wait.
    always_comb begin
        hz1     = (m1 != '0) && ld1 && (m1 < stage_idx_t'(LOAD_RDY));
        hz2     = (m2 != '0) && ld2 && (m2 < stage_idx_t'(LOAD_RDY));
        sel1    = hz1 ? '0 : fwd_sel_t'(m1);
        sel2    = hz2 ? '0 : fwd_sel_t'(m2);
        // flush kills the decode slot anyway, so a hazard on it is moot.
        stall_w = bus.mem_wait || (bus.id_valid && (hz1 || hz2) && !bus.flush);
        issue_w = bus.id_valid && !stall_w && !bus.flush;
    end

    always_comb begin
        busy_w = 1'b0;
        for (int s = 1; s <= DEPTH; s++) begin
            busy_w = busy_w | ent[s].valid;
        end
    end

    // Shift network: decode feeds entry 1 (bubble unless issued), each entry
    // feeds the next, the last entry retires.
    always_comb begin
        d_in[1] = '{valid: issue_w,
                    dst:   reg_idx_t'(bus.id_dst),
                    wreg:  bus.id_wreg,
                    load:  bus.id_load};
        for (int s = 2; s <= DEPTH; s++) begin
            d_in[s] = ent[s-1];
        end
    end

    for (genvar g = 1; g <= DEPTH; g++) begin : g_stage
        scoreboard_stage u_stage (
            .clk (clk),
            .rst (rst),
            .en  (!bus.mem_wait),
            .d   (d_in[g]),
            .q   (ent[g])
        );
    end

    // Saturating event counters. A flush held during mem_wait is the same
    // jump waiting to complete, so it counts only once the back end moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_w && (stall_cnt_q != {CNTW{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
            if (bus.flush && !bus.mem_wait && (flush_cnt_q != {CNTW{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.stall     = stall_w;
    assign bus.issue     = issue_w;
    assign bus.fwd1      = sel1[FW-1:0];
    assign bus.fwd2      = sel2[FW-1:0];
    assign bus.busy      = busy_w;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard (NREG=16, DEPTH=3, LOAD_RDY=2, CNTW=4).
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vec_cnt = 0;
    int err_cnt = 0;

    hazard_scoreboard_if #(.NREG(16), .DEPTH(3), .CNTW(4)) bus ();

    hazard_scoreboard #(
        .NREG     (16),
        .DEPTH    (3),
        .LOAD_RDY (2),
        .CNTW     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 1'b0;
        bus.id_src1  = '0;
        bus.id_src2  = '0;
        bus.id_use1  = 1'b0;
        bus.id_use2  = 1'b0;
        bus.id_dst   = '0;
        bus.id_wreg  = 1'b0;
        bus.id_load  = 1'b0;
        bus.flush    = 1'b0;
        bus.mem_wait = 1'b0;
    endtask

    // Decode holds a producer writing register d.
    task automatic put_writer(input logic [3:0] d, input logic ld);
        idle();
        bus.id_valid = 1'b1;
        bus.id_dst   = d;
        bus.id_wreg  = 1'b1;
        bus.id_load  = ld;
    endtask

    // Decode holds a consumer (no register write).
    task automatic put_reader(input logic [3:0] s1, input logic u1,
                              input logic [3:0] s2, input logic u2);
        idle();
        bus.id_valid = 1'b1;
        bus.id_src1  = s1;
        bus.id_use1  = u1;
        bus.id_src2  = s2;
        bus.id_use2  = u2;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- reset state
        idle();
        tick();
        tick();
        rst = 1'b0;
        bus.id_valid = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_issue", 32'(bus.issue), 32'd1);
        chk("rst_fwd1", 32'(bus.fwd1), 32'd0);
        chk("rst_fwd2", 32'(bus.fwd2), 32'd0);
        bus.mem_wait = 1'b1;
        #1;
        chk("rst_memwait_stall", 32'(bus.stall), 32'd1);
        chk("rst_memwait_issue", 32'(bus.issue), 32'd0);

        // ---------------- ALU r3 in EX, read r3 on src1
        do_reset();
        put_writer(4'd3, 1'b0);
        #1;
        chk("alu_issue_prod", 32'(bus.issue), 32'd1);
        tick();
        put_reader(4'd3, 1'b1, 4'd3, 1'b0);
        #1;
        chk("alu_fwd1", 32'(bus.fwd1), 32'd1);
        chk("alu_fwd2_unused", 32'(bus.fwd2), 32'd0);
        chk("alu_stall", 32'(bus.stall), 32'd0);
        chk("alu_issue", 32'(bus.issue), 32'd1);
        chk("alu_busy", 32'(bus.busy), 32'd1);

        // ---------------- load r5 in EX, read r5 on src2: one stall cycle
        do_reset();
        put_writer(4'd5, 1'b1);
        tick();
        put_reader(4'd0, 1'b0, 4'd5, 1'b1);
        #1;
        chk("lu_stall", 32'(bus.stall), 32'd1);
        chk("lu_issue", 32'(bus.issue), 32'd0);
        chk("lu_fwd2_hold", 32'(bus.fwd2), 32'd0);
        tick();
        chk("lu_stall_after", 32'(bus.stall), 32'd0);
        chk("lu_fwd2_mem", 32'(bus.fwd2), 32'd2);
        chk("lu_issue_after", 32'(bus.issue), 32'd1);
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // ---------------- r7 in EX and MEM: youngest wins
        do_reset();
        put_writer(4'd7, 1'b0);
        tick();
        put_writer(4'd7, 1'b0);
        tick();
        put_reader(4'd7, 1'b1, 4'd7, 1'b1);
        #1;
        chk("young_fwd1", 32'(bus.fwd1), 32'd1);
        chk("young_fwd2", 32'(bus.fwd2), 32'd1);

        // ---------------- producer in last stage forwards from stage DEPTH
        do_reset();
        put_writer(4'd9, 1'b0);
        tick();
        idle();
        tick();
        tick();
        put_reader(4'd9, 1'b1, 4'd0, 1'b0);
        #1;
        chk("wb_fwd1", 32'(bus.fwd1), 32'd3);
        chk("wb_busy", 32'(bus.busy), 32'd1);
        idle();
        tick();
        put_reader(4'd9, 1'b1, 4'd0, 1'b0);
        #1;
        chk("retired_fwd1", 32'(bus.fwd1), 32'd0);
        chk("retired_busy", 32'(bus.busy), 32'd0);

        // ---------------- load-use hazard with flush in the same cycle
        do_reset();
        put_writer(4'd5, 1'b1);
        tick();
        put_reader(4'd0, 1'b0, 4'd5, 1'b1);
        bus.id_wreg = 1'b1;
        bus.id_dst  = 4'd6;
        bus.flush   = 1'b1;
        #1;
        chk("fl_stall", 32'(bus.stall), 32'd0);
        chk("fl_issue", 32'(bus.issue), 32'd0);
        tick();
        chk("fl_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("fl_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        put_reader(4'd6, 1'b1, 4'd5, 1'b1);
        #1;
        chk("fl_bubble_fwd1", 32'(bus.fwd1), 32'd0);
        chk("fl_load_fwd2", 32'(bus.fwd2), 32'd2);
        chk("fl_no_stall", 32'(bus.stall), 32'd0);

        // ---------------- mem_wait for 4 cycles with 3 valid entries
        do_reset();
        put_writer(4'd1, 1'b0);
        tick();
        put_writer(4'd2, 1'b0);
        tick();
        put_writer(4'd3, 1'b0);
        tick();
        put_reader(4'd1, 1'b1, 4'd2, 1'b1);
        bus.mem_wait = 1'b1;
        bus.flush    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mw_stall_%0d", i), 32'(bus.stall), 32'd1);
            chk($sformatf("mw_issue_%0d", i), 32'(bus.issue), 32'd0);
            chk($sformatf("mw_busy_%0d", i), 32'(bus.busy), 32'd1);
            chk($sformatf("mw_fwd1_%0d", i), 32'(bus.fwd1), 32'd3);
            chk($sformatf("mw_fwd2_%0d", i), 32'(bus.fwd2), 32'd2);
            tick();
        end
        chk("mw_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        chk("mw_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        bus.mem_wait = 1'b0;
        bus.flush    = 1'b0;
        #1;
        chk("mw_release_issue", 32'(bus.issue), 32'd1);
        chk("mw_release_fwd1", 32'(bus.fwd1), 32'd3);

        // ---------------- counter saturation, then reset mid-stream
        do_reset();
        bus.mem_wait = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) chk("sat_stall_14", 32'(bus.stall_cnt), 32'd14);
        end
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd15);
        idle();
        bus.flush = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        chk("sat_flush_cnt", 32'(bus.flush_cnt), 32'd15);
        chk("sat_stall_hold", 32'(bus.stall_cnt), 32'd15);
        put_writer(4'd4, 1'b0);
        tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        bus.mem_wait = 1'b1;
        bus.flush    = 1'b1;
        rst = 1'b1;
        tick();
        chk("mid_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("mid_rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        idle();
        bus.id_valid = 1'b1;
        #1;
        chk("post_rst_issue", 32'(bus.issue), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
